// File: rtl/awg_segment_scheduler.sv
// Segment sequencer for one waveform channel: plays a table of {duration, amp, interval}
// entries, issuing one trigger per segment only after the channel's WORK window has elapsed.
module awg_segment_scheduler #(
  parameter int unsigned WAVE_LENGTH = 32'd100000000,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              user_clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [27:0]       cfg_wdata,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [7:0]        i_loop_count,
  input  logic [15:0]       i_gap,
  output logic              o_trigger,
  output logic [7:0]        o_duration,
  output logic [15:0]       o_amp,
  output logic [3:0]        o_interval,
  output logic [ADDR_W-1:0] o_seg_idx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CycW  = (WAVE_LENGTH > 1) ? $clog2(WAVE_LENGTH) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(WAVE_LENGTH - 1);

  typedef enum logic [2:0] {StIdle, StFire, StRun, StGap, StEnd} state_e;

  state_e            state_q;
  logic [27:0]       tbl_q [Depth];
  logic [ADDR_W-1:0] idx_q;
  logic [CycW-1:0]   cyc_q;
  logic [7:0]        unit_q;
  logic [15:0]       gap_cnt_q;
  logic [15:0]       gap_q;
  logic [7:0]        pass_q;
  logic              inf_q;
  logic              abort_q;
  logic              trigger_q, busy_q, done_q;
  logic [7:0]        duration_q;
  logic [15:0]       amp_q;
  logic [3:0]        interval_q;
  logic [ADDR_W-1:0] seg_idx_q;

  logic [ADDR_W-1:0] idx_inc, fire_idx;
  logic [27:0]       fire_entry;
  logic              pass_end, run_last, gap_last, step, abort_any, more;
  logic              start_ok, entry0_zero, go_fire, go_end;

  // Next-step decision shared by the end of RUN (no gap) and the end of GAP.
  always_comb begin
    idx_inc     = idx_q + ADDR_W'(1);
    pass_end    = (idx_q == {ADDR_W{1'b1}}) || (tbl_q[idx_inc][27:20] == 8'd0);
    run_last    = (state_q == StRun) && (cyc_q == CycLast) && (unit_q == duration_q - 8'd1);
    gap_last    = (state_q == StGap) && (gap_cnt_q == gap_q - 16'd1);
    step        = (run_last && (gap_q == 16'd0)) || gap_last;
    abort_any   = abort_q || i_abort;
    more        = !pass_end || inf_q || (pass_q > 8'd1);
    start_ok    = (state_q == StIdle) && !cfg_we && i_start && !i_abort;
    entry0_zero = (tbl_q[0][27:20] == 8'd0);
    go_fire     = (start_ok && !entry0_zero) || (step && !abort_any && more);
    go_end      = (start_ok && entry0_zero) || (step && (abort_any || !more));
    fire_idx    = (start_ok || pass_end) ? '0 : idx_inc;
    fire_entry  = tbl_q[fire_idx];
  end

  // Sequencer FSM, table storage and registered channel outputs.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      for (int i = 0; i < Depth; i++) tbl_q[i] <= '0;
      idx_q      <= '0;
      cyc_q      <= '0;
      unit_q     <= '0;
      gap_cnt_q  <= '0;
      gap_q      <= '0;
      pass_q     <= '0;
      inf_q      <= 1'b0;
      abort_q    <= 1'b0;
      trigger_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      duration_q <= '0;
      amp_q      <= '0;
      interval_q <= '0;
      seg_idx_q  <= '0;
    end else begin
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cfg_we) begin
            tbl_q[cfg_addr] <= cfg_wdata;
          end else if (start_ok) begin
            pass_q <= i_loop_count;
            inf_q  <= (i_loop_count == 8'd0);
            gap_q  <= i_gap;
            idx_q  <= '0;
          end
        end
        StFire: state_q <= StRun;
        StRun: begin
          if (cyc_q == CycLast) begin
            cyc_q  <= '0;
            unit_q <= unit_q + 8'd1;
          end else begin
            cyc_q <= cyc_q + CycW'(1);
          end
          if (run_last && (gap_q != 16'd0)) begin
            state_q   <= StGap;
            gap_cnt_q <= '0;
          end
        end
        StGap: gap_cnt_q <= gap_cnt_q + 16'd1;
        StEnd: begin
          state_q <= StIdle;
          abort_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      // The channel cannot be stopped mid-segment, so abort only blocks the next FIRE.
      if (busy_q && i_abort) abort_q <= 1'b1;
      if (step && pass_end && !abort_any && !inf_q) pass_q <= pass_q - 8'd1;

      if (go_fire) begin
        state_q    <= StFire;
        trigger_q  <= 1'b1;
        busy_q     <= 1'b1;
        idx_q      <= fire_idx;
        seg_idx_q  <= fire_idx;
        duration_q <= fire_entry[27:20];
        amp_q      <= fire_entry[19:4];
        interval_q <= fire_entry[3:0];
        cyc_q      <= '0;
        unit_q     <= '0;
      end
      if (go_end) begin
        state_q    <= StEnd;
        done_q     <= 1'b1;
        busy_q     <= 1'b0;
        duration_q <= '0;
        amp_q      <= '0;
        interval_q <= '0;
        seg_idx_q  <= '0;
      end
    end
  end

  assign o_trigger  = trigger_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_duration = duration_q;
  assign o_amp      = amp_q;
  assign o_interval = interval_q;
  assign o_seg_idx  = seg_idx_q;

endmodule
